// File: rtl/fifo_async_pkg.sv
// fifo_async_pkg: pointer-width helper and binary/Gray conversions for the async FIFO.
package fifo_async_pkg;
   localparam int GRAY_MAX_W = 32;
   typedef logic [GRAY_MAX_W-1:0] gray_word_t;
   function automatic int ptr_width(input int mem_length);
      return $clog2(mem_length) + 1;
   endfunction
   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b = g;
      for (int i = 1; i < GRAY_MAX_W; i++) b = b ^ (g >> i);
      return b;
   endfunction
endpackage

// File: rtl/fifo_async_sync.sv
// fifo_async_sync: CHAIN_LENGTH-deep flop synchronizer with async active-low reset.
module fifo_async_sync #(
   parameter int WIDTH        = 1,
   parameter int CHAIN_LENGTH = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] chain [CHAIN_LENGTH];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         for (int i = 0; i < CHAIN_LENGTH; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < CHAIN_LENGTH; i++) chain[i] <= chain[i-1];
      end
   assign q = chain[CHAIN_LENGTH-1];
endmodule

// File: rtl/fifo_async.sv
// fifo_async: dual-clock first-word-fall-through FIFO with Gray-coded pointer crossings.
// Define FIFO_ASYNC_ASSERT_EN for parameter checks and overflow/underflow warnings.
module fifo_async
   import fifo_async_pkg::*;
#(
   parameter int CHAIN_LENGTH = 3,
   parameter int MEM_LENGTH   = 4,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clk_src,
   input  logic                  reset_master_src_n,
   input  logic                  clk_dest,
   input  logic                  reset_master_dest_n,
   input  logic                  write_en,
   input  logic [DATA_WIDTH-1:0] data_src,
   input  logic                  read_en,
   output logic                  full,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] data_dest
);
   localparam int PW = ptr_width(MEM_LENGTH);
   localparam int AW = PW - 1;
   // Full compares against the remote pointer with its two MSBs inverted.
   localparam logic [PW-1:0] FULL_MASK = {PW{1'b1}} ^ ({PW{1'b1}} >> 2);
   logic [DATA_WIDTH-1:0] mem [MEM_LENGTH];
   logic [PW-1:0] wr_bin, wr_gray, wr_bin_next, rd_gray_sync;
   logic [PW-1:0] rd_bin, rd_gray, rd_bin_next, wr_gray_sync;
   logic wr_ok, rd_ok;
   assign wr_ok       = write_en & ~full;
   assign rd_ok       = read_en & ~empty;
   assign wr_bin_next = wr_bin + 1'b1;
   assign rd_bin_next = rd_bin + 1'b1;
   always_ff @(posedge clk_src or negedge reset_master_src_n)
      if (!reset_master_src_n) begin
         wr_bin  <= '0;
         wr_gray <= '0;
      end else if (wr_ok) begin
         wr_bin  <= wr_bin_next;
         wr_gray <= PW'(bin2gray(gray_word_t'(wr_bin_next)));
      end
   always_ff @(posedge clk_src)
      if (wr_ok) mem[wr_bin[AW-1:0]] <= data_src;
   always_ff @(posedge clk_dest or negedge reset_master_dest_n)
      if (!reset_master_dest_n) begin
         rd_bin  <= '0;
         rd_gray <= '0;
      end else if (rd_ok) begin
         rd_bin  <= rd_bin_next;
         rd_gray <= PW'(bin2gray(gray_word_t'(rd_bin_next)));
      end
   fifo_async_sync #(.WIDTH(PW), .CHAIN_LENGTH(CHAIN_LENGTH)) u_sync_rd (
      .clk(clk_src), .reset_n(reset_master_src_n), .d(rd_gray), .q(rd_gray_sync)
   );
   fifo_async_sync #(.WIDTH(PW), .CHAIN_LENGTH(CHAIN_LENGTH)) u_sync_wr (
      .clk(clk_dest), .reset_n(reset_master_dest_n), .d(wr_gray), .q(wr_gray_sync)
   );
   assign full      = wr_gray == (rd_gray_sync ^ FULL_MASK);
   assign empty     = rd_gray == wr_gray_sync;
   assign data_dest = mem[rd_bin[AW-1:0]];
`ifdef FIFO_ASYNC_ASSERT_EN
   if ((MEM_LENGTH < 2) || ((MEM_LENGTH & (MEM_LENGTH - 1)) != 0)) begin : g_bad_mem
      $error("fifo_async: MEM_LENGTH %0d must be a power of two >= 2", MEM_LENGTH);
   end
   if (CHAIN_LENGTH < 2) begin : g_bad_chain
      $error("fifo_async: CHAIN_LENGTH %0d must be >= 2", CHAIN_LENGTH);
   end
   always_ff @(posedge clk_src)
      assert (!(write_en && full)) else $warning("fifo_async: write while full ignored");
   always_ff @(posedge clk_dest)
      assert (!(read_en && empty)) else $warning("fifo_async: read while empty ignored");
`endif
endmodule

// File: tb/tb_fifo_async.sv
// tb_fifo_async: directed scoreboard bench for fifo_async (default and 8-deep/2-flop builds).
module tb_fifo_async;
   logic clk_a = 1'b0;
   logic clk_b = 1'b0;
   always #5 clk_a = ~clk_a;
   always #8 clk_b = ~clk_b;

   logic        rst_n, we, re, full, empty, we2, re2, full2, empty2;
   logic [31:0] din, dout, din2, dout2;
   logic [31:0] q[$];
   logic [31:0] q2[$];
   int n_chk = 0;
   int n_fail = 0;

   fifo_async dut (
      .clk_src(clk_a), .reset_master_src_n(rst_n), .clk_dest(clk_b), .reset_master_dest_n(rst_n),
      .write_en(we), .data_src(din), .read_en(re), .full(full), .empty(empty), .data_dest(dout)
   );

   fifo_async #(.CHAIN_LENGTH(2), .MEM_LENGTH(8), .DATA_WIDTH(32)) dut2 (
      .clk_src(clk_b), .reset_master_src_n(rst_n), .clk_dest(clk_a), .reset_master_dest_n(rst_n),
      .write_en(we2), .data_src(din2), .read_en(re2), .full(full2), .empty(empty2), .data_dest(dout2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic align_a();
      @(posedge clk_a); #1;
   endtask

   task automatic do_write(input logic [31:0] d);
      logic acc;
      acc = !full;
      we  = 1'b1;
      din = d;
      @(posedge clk_a); #1;
      we = 1'b0;
      if (acc) q.push_back(d);
   endtask

   task automatic do_read(input string tag);
      int n;
      logic [31:0] exp;
      n = 0;
      @(posedge clk_b); #1;
      while (empty && n < 10) begin
         @(posedge clk_b); #1;
         n++;
      end
      chk({tag, "_ready"}, 32'(empty), 32'(0));
      if (!empty) begin
         exp = (q.size() != 0) ? q.pop_front() : 32'hDEAD_DEAD;
         chk(tag, dout, exp);
         re = 1'b1;
         @(posedge clk_b); #1;
         re = 1'b0;
      end
   endtask

   task automatic wait_full_clear();
      int n;
      n = 0;
      while (full && n < 8) begin
         @(posedge clk_a); #1;
         n++;
      end
      chk("full_clear", 32'(full), 32'(0));
   endtask

   int v, gw, got, gr, v2, gw2, got2, gr2;
   logic acc_w, acc_w2;
   logic [31:0] exp_r, exp_r2;

   initial begin
      rst_n = 1'b0; we = 1'b0; re = 1'b0; din = '0;
      we2 = 1'b0; re2 = 1'b0; din2 = '0;
      #43;
      chk("rst_full", 32'(full), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      chk("rst_full2", 32'(full2), 32'(0));
      chk("rst_empty2", 32'(empty2), 32'(1));
      rst_n = 1'b1;

      // basic fill and drain
      align_a();
      for (int i = 1; i <= 4; i++) do_write(32'(i));
      chk("full_after_4", 32'(full), 32'(1));
      for (int i = 0; i < 4; i++) do_read("basic");
      chk("empty_after_4", 32'(empty), 32'(1));
      align_a();
      wait_full_clear();

      // write while full is dropped
      for (int i = 1; i <= 4; i++) do_write(32'(i));
      do_write(32'd5);
      chk("full_hold", 32'(full), 32'(1));
      for (int i = 0; i < 4; i++) do_read("ovf_drop");
      chk("empty_drain", 32'(empty), 32'(1));
      repeat (8) @(posedge clk_b);
      #1;
      chk("no_word_5", 32'(empty), 32'(1));

      // read while empty after reset
      rst_n = 1'b0;
      #23;
      rst_n = 1'b1;
      q.delete();
      @(posedge clk_b); #1;
      re = 1'b1;
      repeat (3) @(posedge clk_b);
      #1;
      re = 1'b0;
      chk("empty_udf", 32'(empty), 32'(1));
      align_a();
      do_write(32'd9);
      do_read("after_udf");
      chk("empty_after_9", 32'(empty), 32'(1));

      // wrap-around stream 1..20
      fork
         begin
            v = 1; gw = 0;
            align_a();
            while (v <= 20 && gw < 500) begin
               acc_w = !full;
               we = 1'b1;
               din = 32'(v);
               @(posedge clk_a); #1;
               if (acc_w) begin
                  q.push_back(32'(v));
                  v++;
               end
               gw++;
            end
            we = 1'b0;
         end
         begin
            got = 0; gr = 0;
            @(posedge clk_b); #1;
            re = 1'b1;
            while (got < 20 && gr < 1000) begin
               if (!empty) begin
                  exp_r = (q.size() != 0) ? q.pop_front() : 32'hDEAD_DEAD;
                  chk("stream", dout, exp_r);
                  got++;
               end
               @(posedge clk_b); #1;
               gr++;
            end
            re = 1'b0;
         end
      join
      chk("stream_count", 32'(got), 32'(20));
      chk("stream_empty", 32'(empty), 32'(1));

      // reset with data queued
      align_a();
      wait_full_clear();
      do_write(32'd11);
      do_write(32'd12);
      do_write(32'd13);
      repeat (6) @(posedge clk_b);
      #1;
      chk("queued_nonempty", 32'(empty), 32'(0));
      rst_n = 1'b0;
      #1;
      chk("midrst_full", 32'(full), 32'(0));
      chk("midrst_empty", 32'(empty), 32'(1));
      q.delete();
      #22;
      rst_n = 1'b1;
      align_a();
      do_write(32'd7);
      do_read("after_midrst");
      chk("empty_after_7", 32'(empty), 32'(1));

      // swapped clocks, 8 deep, 2-flop chain, random throttling
      fork
         begin
            v2 = 1; gw2 = 0;
            @(posedge clk_b); #1;
            while (v2 <= 30 && gw2 < 2000) begin
               we2 = ($urandom_range(0, 3) != 0);
               din2 = 32'(v2) + 32'h100;
               acc_w2 = we2 && !full2;
               @(posedge clk_b); #1;
               if (acc_w2) begin
                  q2.push_back(32'(v2) + 32'h100);
                  v2++;
                  chk("sweep_overflow", 32'(q2.size() <= 8), 32'(1));
               end
               gw2++;
            end
            we2 = 1'b0;
         end
         begin
            got2 = 0; gr2 = 0;
            @(posedge clk_a); #1;
            while (got2 < 30 && gr2 < 4000) begin
               re2 = 1'($urandom_range(0, 1));
               if (re2 && !empty2) begin
                  chk("sweep_underflow", 32'(q2.size() != 0), 32'(1));
                  exp_r2 = (q2.size() != 0) ? q2.pop_front() : 32'hDEAD_DEAD;
                  chk("sweep_order", dout2, exp_r2);
                  got2++;
               end
               @(posedge clk_a); #1;
               gr2++;
            end
            re2 = 1'b0;
         end
      join
      chk("sweep_count", 32'(got2), 32'(30));
      chk("sweep_empty", 32'(empty2), 32'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_async.md
FIFO_ASYNC -- requirements
Module: fifo_async

Interface
REQ-001 Parameter CHAIN_LENGTH, default 3: number of synchronizer flops per crossing pointer; legal values are 2 or more.
REQ-002 Parameter MEM_LENGTH, default 4: storage depth in words; legal values are powers of two, 2 or more.
REQ-003 Parameter DATA_WIDTH, default 32: word width in bits.
REQ-004 clk_src  input  1  write-domain clock.
REQ-005 reset_master_src_n  input  1  write-domain reset, asynchronous, active-low.
REQ-006 clk_dest  input  1  read-domain clock, unrelated to clk_src.
REQ-007 reset_master_dest_n  input  1  read-domain reset, asynchronous, active-low.
REQ-008 write_en  input  1  write request, sampled on clk_src rising edge.
REQ-009 data_src  input  DATA_WIDTH  write data, sampled with write_en.
REQ-010 read_en  input  1  read request, sampled on clk_dest rising edge.
REQ-011 full  output  1  clk_src domain; no write is accepted while high.
REQ-012 empty  output  1  clk_dest domain; no read is accepted while high.
REQ-013 data_dest  output  DATA_WIDTH  head-of-queue word (first-word fall-through).

Function
REQ-014 A write is accepted on a clk_src rising edge when write_en=1 and full=0: store data_src at the write address, then increment the write pointer.
REQ-015 A read is accepted on a clk_dest rising edge when read_en=1 and empty=0: increment the read pointer.
REQ-016 Write while full and read while empty are ignored; pointers and storage stay unchanged.
REQ-017 Pointers are log2(MEM_LENGTH)+1 bits wide, counting in binary; each domain keeps a registered Gray copy of its own pointer.
REQ-018 Only the registered Gray pointer crosses domains, through CHAIN_LENGTH flops clocked by the receiving clock.
REQ-019 full=1 exactly when the local Gray write pointer equals the synchronized Gray read pointer with its two MSBs inverted and all other bits equal.
REQ-020 empty=1 exactly when the local Gray read pointer equals the synchronized Gray write pointer.
REQ-021 full asserts in the same clk_src cycle the last free slot is written, with no synchronizer delay.
REQ-022 empty asserts in the same clk_dest cycle the last word is read.
REQ-023 empty deasserts within CHAIN_LENGTH+1 clk_dest rising edges after the write is accepted.
REQ-024 full deasserts within CHAIN_LENGTH+1 clk_src rising edges after the read is accepted.
REQ-025 data_dest is combinational from memory at the read address; it is valid only while empty=0 and shows the next word before read_en.
REQ-026 Pointers wrap modulo 2*MEM_LENGTH; addresses wrap modulo MEM_LENGTH.
REQ-027 Simultaneous write and read in the two domains are independent; order is preserved at all times.

Reset
REQ-028 reset_master_src_n low clears the write pointers and the read-pointer synchronizer; full=0.
REQ-029 reset_master_dest_n low clears the read pointers and the write-pointer synchronizer; empty=1; data_dest is don't-care.
REQ-030 Both resets assert asynchronously; their deassertion arrives already synchronized by one external reset_synchronizer per domain.
REQ-031 Both resets are asserted together, including a reset mid-operation; all queued data is discarded.
REQ-032 Storage memory is not reset.

Configuration
REQ-033 Macro FIFO_ASYNC_ASSERT_EN defined: simulation assertions check that MEM_LENGTH is a power of two and CHAIN_LENGTH is 2 or more at elaboration.
REQ-034 With FIFO_ASYNC_ASSERT_EN defined, a warning is reported on each write attempted while full and each read attempted while empty.
REQ-035 Macro FIFO_ASYNC_ASSERT_EN undefined: no assertions are compiled; functional behaviour is identical.

Structure
REQ-036 Shared package fifo_async_pkg holds the bin-to-Gray and Gray-to-bin functions and a pointer-width helper function, clog2-based.
REQ-037 One sub-module, fifo_async_sync, is a parameterized-width, CHAIN_LENGTH-deep flop synchronizer with asynchronous active-low reset, instantiated once per direction.

Verification
REQ-038 Defaults; clk_src 10 ns, clk_dest 16 ns; write 1,2,3,4 on consecutive edges -> full=1 after the 4th write; empty=0 within 4 clk_dest edges; read -> data_dest 1,2,3,4 in order; empty=1 after the 4th read.
REQ-039 Fill 4 words, then write 5 while full -> ignored; the read sequence is 1,2,3,4 with no 5.
REQ-040 Read while empty after reset -> empty stays 1; pointers are unchanged; a subsequent write of 9 reads back as 9.
REQ-041 Wrap-around: stream 1..20 with continuous read_en and write_en throttled by full -> output is exactly 1..20 in order; no duplicates or losses.
REQ-042 Reset mid-operation: 3 words queued, both resets asserted -> full=0, empty=1 immediately; after release, a write of 7 reads back as 7.
REQ-043 Sweep: ratio-swapped clocks (clk_src 16 ns, clk_dest 10 ns) with CHAIN_LENGTH=2, MEM_LENGTH=8 -> order is preserved; the flags never permit overflow or underflow.
